// File: rtl/mem_responder.sv
// Purpose: 64-bit word memory model answering LOAD/STORE commands with a rotating 4-bit tag.
// Latency: accept/response combinational; load data returns MEM_LAT cycles after accept, one per cycle, in order.
// Backpressure: mem_stall_i refuses every command; the return pipeline keeps draining regardless.
// Optional feature: define MEM_ADDR_CHK_EN to refuse misaligned/out-of-range addresses and raise a sticky mem_err_o.
module mem_responder #(
    parameter int MEM_LAT   = 4,
    parameter int MEM_IDX_W = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  proc2mem_command_i,
    input  logic [63:0] proc2mem_addr_i,
    input  logic [63:0] proc2mem_data_i,
    input  logic        mem_stall_i,
    output logic [3:0]  mem2proc_response_o,
    output logic [63:0] mem2proc_data_o,
    output logic [3:0]  mem2proc_tag_o,
    output logic        mem_err_o
);

    localparam int DEPTH = 1 << MEM_IDX_W;

    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    // One return-pipeline slot; tag 0 marks an empty slot.
    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] dat;
    } ret_t;

    logic [63:0]          mem [DEPTH];
    logic [MEM_IDX_W-1:0] idx;
    logic                 cmd_ld;
    logic                 cmd_st;
    logic                 addr_ok;
    logic                 accept;
    logic                 ld_acc;
    logic [3:0]           tag_cnt;
    logic [63:0]          rd_dat;
    ret_t                 new_ret;
    ret_t                 pipe [MEM_LAT];

    assign idx    = proc2mem_addr_i[MEM_IDX_W+2:3];
    assign cmd_ld = (proc2mem_command_i == BUS_LOAD);
    assign cmd_st = (proc2mem_command_i == BUS_STORE);

`ifdef MEM_ADDR_CHK_EN
    // Word-aligned and inside the array, otherwise the command is refused.
    assign addr_ok = (proc2mem_addr_i[2:0] == 3'd0) &&
                     ((proc2mem_addr_i >> (MEM_IDX_W + 3)) == 64'd0);
`else
    // Without checking the index simply wraps; the dropped bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{proc2mem_addr_i[63:MEM_IDX_W+3], proc2mem_addr_i[2:0]};
    assign addr_ok          = 1'b1;
`endif

    // Reset gates acceptance so nothing is accepted or written while rst is low.
    assign accept = rst && (cmd_ld || cmd_st) && !mem_stall_i && addr_ok;
    assign ld_acc = accept && cmd_ld;

    assign mem2proc_response_o = accept ? tag_cnt : 4'd0;

    // Read in the accept cycle: sees all earlier stores, never a later one.
    assign rd_dat = mem[idx];

    // Build the slot entering the pipeline this cycle (empty unless a load is accepted).
    always_comb begin
        new_ret = '0;
        if (ld_acc) begin
            new_ret.tag = tag_cnt;
            new_ret.dat = rd_dat;
        end
    end

    // Tag counter: starts at 1, advances per accept, skips 0 on wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_cnt <= 4'd1;
        end else if (accept) begin
            tag_cnt <= (tag_cnt == 4'd15) ? 4'd1 : tag_cnt + 4'd1;
        end
    end

    // Store port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && cmd_st) begin
            mem[idx] <= proc2mem_data_i;
        end
    end

    // Fixed-length return shift register; the last slot drives the outputs directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= new_ret;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign mem2proc_tag_o  = pipe[MEM_LAT-1].tag;
    assign mem2proc_data_o = pipe[MEM_LAT-1].dat;

`ifdef MEM_ADDR_CHK_EN
    // Sticky error on any LOAD/STORE with a bad address; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_err_o <= 1'b0;
        end else if ((cmd_ld || cmd_st) && !addr_ok) begin
            mem_err_o <= 1'b1;
        end
    end
`else
    assign mem_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder at MEM_LAT=4.
// Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
// Expected values are hand-derived constants and a tiny address/data lookup.
module tb_mem_responder;

    localparam int LAT = 4;

    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic        clk;
    logic        rst;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] wdat;
    logic        stall;
    logic [3:0]  resp;
    logic [63:0] rdat;
    logic [3:0]  rtag;
    logic        err;

    int n_chk;
    int n_fail;

    mem_responder #(
        .MEM_LAT   (LAT),
        .MEM_IDX_W (13)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .proc2mem_command_i  (cmd),
        .proc2mem_addr_i     (addr),
        .proc2mem_data_i     (wdat),
        .mem_stall_i         (stall),
        .mem2proc_response_o (resp),
        .mem2proc_data_o     (rdat),
        .mem2proc_tag_o      (rtag),
        .mem_err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
        cmd  = c;
        addr = a;
        wdat = d;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles expecting no return.
    task automatic idle_quiet(input int n, input string tag);
        drive(NONE, 64'h0, 64'h0);
        for (int k = 0; k < n; k++) begin
            settle();
            chk(tag, {60'h0, rtag}, 64'h0);
            adv();
        end
    endtask

    function automatic logic [63:0] loop_addr(input int i);
        case (i % 3)
            0:       return 64'h40;
            1:       return 64'h100;
            default: return 64'h80;
        endcase
    endfunction

    function automatic logic [63:0] loop_dat(input int i);
        case (i % 3)
            0:       return 64'hDEAD_BEEF;
            1:       return 64'h5;
            default: return 64'h1234;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        stall  = 1'b0;
        drive(NONE, 64'h0, 64'h0);
        repeat (3) adv();

        // A command during reset is refused; outputs idle.
        drive(LOAD, 64'h0, 64'h0);
        settle();
        chk("rst_resp", {60'h0, resp}, 64'h0);
        chk("rst_tag",  {60'h0, rtag}, 64'h0);
        chk("rst_data", rdat, 64'h0);
        chk("rst_err",  {63'h0, err}, 64'h0);
        adv();

        // Store then load of 0x40.
        rst = 1'b1;
        drive(STORE, 64'h40, 64'hDEAD_BEEF);
        settle();
        chk("st40_resp", {60'h0, resp}, 64'h1);
        adv();
        drive(LOAD, 64'h40, 64'h0);
        settle();
        chk("ld40_resp", {60'h0, resp}, 64'h2);
        adv();
        idle_quiet(LAT - 1, "ld40_early");
        settle();
        chk("ld40_tag",  {60'h0, rtag}, 64'h2);
        chk("ld40_data", rdat, 64'hDEAD_BEEF);
        adv();
        settle();
        chk("ld40_tag_one_cycle",  {60'h0, rtag}, 64'h0);
        chk("ld40_data_one_cycle", rdat, 64'h0);
        adv();

        // Load sees the value before a store accepted one cycle later.
        drive(STORE, 64'h100, 64'h77);
        settle();
        chk("st100a_resp", {60'h0, resp}, 64'h3);
        adv();
        drive(LOAD, 64'h100, 64'h0);
        settle();
        chk("ld100a_resp", {60'h0, resp}, 64'h4);
        adv();
        drive(STORE, 64'h100, 64'h5);
        settle();
        chk("st100b_resp", {60'h0, resp}, 64'h5);
        adv();
        drive(LOAD, 64'h100, 64'h0);
        settle();
        chk("ld100b_resp", {60'h0, resp}, 64'h6);
        adv();
        drive(NONE, 64'h0, 64'h0);
        settle();
        chk("ld100_quiet", {60'h0, rtag}, 64'h0);
        adv();
        settle();
        chk("ld100a_tag",  {60'h0, rtag}, 64'h4);
        chk("ld100a_data", rdat, 64'h77);
        adv();
        settle();
        chk("st_no_return", {60'h0, rtag}, 64'h0);
        adv();
        settle();
        chk("ld100b_tag",  {60'h0, rtag}, 64'h6);
        chk("ld100b_data", rdat, 64'h5);
        adv();

        // Stall refuses; dropping the stall accepts with the next tag.
        drive(STORE, 64'h80, 64'h1234);
        settle();
        chk("st80_resp", {60'h0, resp}, 64'h7);
        adv();
        stall = 1'b1;
        drive(LOAD, 64'h80, 64'h0);
        settle();
        chk("stall_resp", {60'h0, resp}, 64'h0);
        adv();
        stall = 1'b0;
        settle();
        chk("unstall_resp", {60'h0, resp}, 64'h8);
        adv();
        idle_quiet(LAT - 1, "stall_no_return");
        settle();
        chk("unstall_tag",  {60'h0, rtag}, 64'h8);
        chk("unstall_data", rdat, 64'h1234);
        adv();

        // Two loads in flight, then a one-cycle reset discards them.
        drive(LOAD, 64'h40, 64'h0);
        settle();
        chk("fl0_resp", {60'h0, resp}, 64'h9);
        adv();
        drive(LOAD, 64'h100, 64'h0);
        settle();
        chk("fl1_resp", {60'h0, resp}, 64'hA);
        adv();
        rst = 1'b0;
        drive(LOAD, 64'h80, 64'h0);
        settle();
        chk("midrst_resp", {60'h0, resp}, 64'h0);
        adv();
        rst = 1'b1;
        idle_quiet(5, "flushed_tag");

        // 16 back-to-back loads: tags 1..15 then 1, returns on consecutive cycles.
        for (int t = 0; t < 21; t++) begin
            if (t < 16) drive(LOAD, loop_addr(t), 64'h0);
            else        drive(NONE, 64'h0, 64'h0);
            settle();
            if (t < 16) chk($sformatf("seq_resp%0d", t), {60'h0, resp}, 64'((t % 15) + 1));
            if (t >= LAT && t < 16 + LAT) begin
                chk($sformatf("seq_tag%0d", t - LAT), {60'h0, rtag}, 64'(((t - LAT) % 15) + 1));
                chk($sformatf("seq_data%0d", t - LAT), rdat, loop_dat(t - LAT));
            end else begin
                chk($sformatf("seq_idle%0d", t), {60'h0, rtag}, 64'h0);
            end
            adv();
        end
        settle();
        chk("pre_chk_err", {63'h0, err}, 64'h0);

        // Misaligned load 0x44.
        drive(LOAD, 64'h44, 64'h0);
        settle();
`ifdef MEM_ADDR_CHK_EN
        chk("bad_resp", {60'h0, resp}, 64'h0);
        chk("bad_err_same_cycle", {63'h0, err}, 64'h0);
        adv();
        drive(NONE, 64'h0, 64'h0);
        settle();
        chk("bad_err_set", {63'h0, err}, 64'h1);
        adv();
        idle_quiet(LAT, "bad_no_return");
        settle();
        chk("bad_err_held", {63'h0, err}, 64'h1);
`else
        chk("mis_resp", {60'h0, resp}, 64'h2);
        adv();
        idle_quiet(LAT - 1, "mis_early");
        settle();
        chk("mis_tag",  {60'h0, rtag}, 64'h2);
        chk("mis_data", rdat, 64'hDEAD_BEEF);
        chk("mis_err",  {63'h0, err}, 64'h0);
`endif
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
